// File: rtl/mult_seq_ctrl.sv
// ============================================================================
// mult_seq_ctrl
// ----------------------------------------------------------------------------
// Multi-cycle MULT/MULTU sequencer for the pipelined MIPS core. It drives one
// shared external 32-bit adder (adder32) in shift-and-add fashion and produces
// a 64-bit {hi, lo} product in a fixed 37 cycles. The latency does not depend
// on the operands.
//
// Signed operands are handled in three steps:
//   1. Take the magnitude of each operand.
//   2. Run an unsigned multiply on the magnitudes.
//   3. Negate the 64-bit result if the operand signs differ.
// Every step uses the same adder, so no extra adder is needed.
//
// Ports
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous active-high reset
//   start      in   1    request; sampled only in IDLE
//   is_signed  in   1    1 = MULT, 0 = MULTU; sampled with start
//   op_a       in   32   multiplicand (rs); sampled with start
//   op_b       in   32   multiplier (rt); sampled with start
//   add_a      out  32   operand A to the shared adder32
//   add_b      out  32   operand B to the shared adder32
//   add_sum    in   32   adder32 result (combinational, same cycle)
//   busy       out  1    high whenever the sequencer is not idle
//   done       out  1    one-cycle pulse; hi/lo are valid from this cycle
//   hi         out  32   product [63:32], held until the next accepted start
//   lo         out  32   product [31:0],  held until the next accepted start
//
// State table
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | waiting for start; adder driven with zeros
//   S_ABS_A  | mcand <= |op_a| when the operation is signed and op_a < 0
//   S_ABS_B  | lo    <= |op_b| when the operation is signed and op_b < 0
//   S_MUL    | 32 shift-and-add iterations on {hi, lo}
//   S_FIX_LO | negate lo if the result sign is negative; latch the borrow
//   S_FIX_HI | negate hi, adding in the carry latched from lo
//   S_DONE   | done pulse; start is ignored here
// ============================================================================
module mult_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_sum,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ABS_A  = 3'd1,
        S_ABS_B  = 3'd2,
        S_MUL    = 3'd3,
        S_FIX_LO = 3'd4,
        S_FIX_HI = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t      state;
    logic [31:0] mcand;
    logic [4:0]  cnt;
    logic        neg;
    logic        sa;
    logic        sb;
    logic        cy;
    logic        mul_cy;

    // The adder has no carry-out, so recover it from the operand and sum MSBs.
    // There is a carry out when both MSBs are set, or when exactly one MSB is
    // set and the sum MSB came out clear.
    assign mul_cy = (hi[31] & mcand[31]) | ((hi[31] | mcand[31]) & ~add_sum[31]);

    // Adder operand mux. It depends only on state and registers, so there is
    // no combinational path from start to the adder.
    always_comb begin
        add_a = 32'd0;
        add_b = 32'd0;
        case (state)
            S_ABS_A: begin
                add_a = ~mcand;
                add_b = 32'd1;
            end
            S_ABS_B: begin
                add_a = ~lo;
                add_b = 32'd1;
            end
            S_MUL: begin
                add_a = hi;
                add_b = mcand;
            end
            S_FIX_LO: begin
                add_a = ~lo;
                add_b = 32'd1;
            end
            S_FIX_HI: begin
                add_a = ~hi;
                add_b = {31'd0, cy};
            end
            default: begin
                add_a = 32'd0;
                add_b = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            hi    <= 32'd0;
            lo    <= 32'd0;
            mcand <= 32'd0;
            cnt   <= 5'd0;
            neg   <= 1'b0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            cy    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= op_a;
                        lo    <= op_b;
                        hi    <= 32'd0;
                        cnt   <= 5'd0;
                        cy    <= 1'b0;
                        neg   <= is_signed & (op_a[31] ^ op_b[31]);
                        sa    <= is_signed & op_a[31];
                        sb    <= is_signed & op_b[31];
                        busy  <= 1'b1;
                        state <= S_ABS_A;
                    end
                end
                S_ABS_A: begin
                    if (sa) begin
                        mcand <= add_sum;
                    end
                    state <= S_ABS_B;
                end
                S_ABS_B: begin
                    // 0x80000000 negates to itself, and reading that as
                    // unsigned 2^31 is the correct magnitude.
                    if (sb) begin
                        lo <= add_sum;
                    end
                    state <= S_MUL;
                end
                S_MUL: begin
                    // lo shifts out the multiplier bits as the product
                    // shifts in from hi.
                    if (lo[0]) begin
                        {hi, lo} <= {mul_cy, add_sum, lo[31:1]};
                    end else begin
                        {hi, lo} <= {1'b0, hi, lo[31:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= S_FIX_LO;
                    end
                end
                S_FIX_LO: begin
                    // Two's complement of {hi, lo}: invert both halves and add
                    // one. The +1 ripples into hi only when lo was zero.
                    if (neg) begin
                        lo <= add_sum;
                        cy <= (lo == 32'd0);
                    end
                    state <= S_FIX_HI;
                end
                S_FIX_HI: begin
                    if (neg) begin
                        hi <= add_sum;
                    end
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// ============================================================================
// tb_mult_seq_ctrl
// ----------------------------------------------------------------------------
// Bench for mult_seq_ctrl.
//   - The driver issues operations and pushes each expected {hi, lo} into a
//     queue.
//   - A monitor pops an entry and compares it on every done pulse.
//   - Directed vectors carry hand-computed results.
//   - Random pairs use a 64-bit reference product computed in the bench.
//   - An ideal 32-bit adder stands in for adder32.
// ============================================================================
module tb_mult_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] expq[$];

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        bit          glitch;
    } vec_t;

    vec_t vecs[10];

    mult_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    assign add_sum = add_a + add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got={%h,%h} want=no_done", hi, lo);
            end else begin
                chk("result", {hi, lo}, expq.pop_front());
            end
        end
    end

    // Called at a negedge and returns at a negedge. When the DUT is already
    // idle, start goes high in the very next cycle, so consecutive calls are
    // back-to-back.
    task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit glitch);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            chk("idle_timeout", {63'd0, busy}, 64'd0);
            return;
        end
        is_signed = sg;
        op_a      = a;
        op_b      = b;
        start     = 1'b1;
        expq.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        n     = 1;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        while (!done && n < 100) begin
            // Starts raised while busy (cycles 5 and 36) must be ignored.
            start     = glitch && (n == 5 || n == 36);
            is_signed = ~sg;
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'd37);
        chk("busy_in_done", {63'd0, busy}, 64'd1);
        // A start held through the done cycle must also be ignored.
        start = glitch;
        @(negedge clk);
        start = 1'b0;
        chk("idle_after_done", {62'd0, busy, done}, 64'd0);
        chk("hold_hilo", {hi, lo}, exp);
        if (glitch) begin
            @(negedge clk);
            chk("start_in_done_ignored", {63'd0, busy}, 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]        ra;
        logic [31:0]        rb;
        logic               rs;
        logic signed [63:0] pa;
        logic signed [63:0] pb;
        logic [63:0]        ref_p;
        int                 n;

        vecs[0] = '{1'b0, 32'd3,         32'd5,         64'h00000000_0000000F, 1'b0};
        vecs[1] = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE_00000001, 1'b0};
        vecs[2] = '{1'b1, 32'hFFFFFFFD,  32'd5,         64'hFFFFFFFF_FFFFFFF1, 1'b0};
        vecs[3] = '{1'b1, 32'h80000000,  32'h80000000,  64'h40000000_00000000, 1'b0};
        vecs[4] = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 1'b0};
        vecs[5] = '{1'b1, 32'hFFFFFFFF,  32'd0,         64'h0, 1'b0};
        vecs[6] = '{1'b0, 32'd0,         32'hDEADBEEF,  64'h0, 1'b0};
        vecs[7] = '{1'b0, 32'h12345678,  32'h10,        64'h00000001_23456780, 1'b1};
        vecs[8] = '{1'b1, 32'd7,         32'hFFFFFFFA,  64'hFFFFFFFF_FFFFFFD6, 1'b0};
        vecs[9] = '{1'b0, 32'h80000000,  32'h2,         64'h00000001_00000000, 1'b0};

        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        #3;
        chk("reset_outputs", {30'd0, busy, done, hi}, 64'd0);
        chk("reset_lo_adder", {lo, add_a | add_b}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {62'd0, busy, done}, 64'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].glitch);
        end

        // Asynchronous reset in the middle of an operation.
        is_signed = 1'b0;
        op_a      = 32'd1000;
        op_b      = 32'd1000;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        while (n < 10) begin
            @(negedge clk);
            n++;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy_done", {62'd0, busy, done}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_restart", {62'd0, busy, done}, 64'd0);
        run_op(1'b0, 32'd7, 32'd6, 64'd42, 1'b0);

        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (rs) begin
                pa    = {{32{ra[31]}}, ra};
                pb    = {{32{rb[31]}}, rb};
                ref_p = pa * pb;
            end else begin
                ref_p = {32'd0, ra} * {32'd0, rb};
            end
            run_op(rs, ra, rb, ref_p, 1'b0);
        end

        n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", 64'(expq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
